// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
//   arbState_t : arbiter FSM state encoding (IDLE is all-zero)
//   SZ_*       : sram-like bus transfer size codes
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_DATA = 3'd2,
    D_ADDR = 3'd3,
    D_DATA = 3'd4,
    D_SKIP = 3'd5
  } arbState_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/ben2size.sv
// Byte-enable to bus transfer size mapping (purely combinational).
//   ben  in  4 : byte-lane enable pattern of the data access
//   size out 2 : SZ_BYTE for a single lane, SZ_HALF for 0011/1100,
//                SZ_WORD for 1111 and every other pattern
module ben2size
  import mem_arb_pkg::*;
(
  input  logic [3:0] ben,
  output logic [1:0] size
);

  always_comb begin
    size = SZ_WORD;
    case (ben)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SZ_BYTE;
      4'b0011, 4'b1100:                   size = SZ_HALF;
      default:                            size = SZ_WORD;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter (instruction fetch, data access) onto a single
// sram-like master port, one bus transaction outstanding at a time.
//   clk, rst          : clock, synchronous active-high reset
//   inst_*            : fetch requester (word reads only)
//   data_*            : data requester (read/write, byte enables)
//   bus_*             : shared sram-like master port
//   arb_busy          : high whenever the FSM is not IDLE
//   dbgState          : current FSM state (debug observation)
//
// Handshake: a requester raises req with its fields and holds them until
// its data_ok pulse. Requests are only sampled in IDLE. On the bus side an
// address phase completes in the cycle bus_req && bus_addr_ok, and the data
// phase completes in the cycle bus_data_ok is seen in the matching DATA state.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_ben,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        arb_busy,
  output logic [2:0]  dbgState
);

  arbState_t   state, stateNext;
  logic        lastWasData;
  logic        grantInst, grantData;
  logic [31:0] addrQ, wdataQ;
  logic        wrQ;
  logic [3:0]  benQ;
  logic [1:0]  dataSize;

  ben2size uBen2size (
    .ben  (benQ),
    .size (dataSize)
  );

  // Next state and grant decision. On a tie the requester that was not
  // granted last wins, which alternates service under constant contention.
  always_comb begin
    stateNext = state;
    grantInst = 1'b0;
    grantData = 1'b0;
    case (state)
      IDLE: begin
        if (inst_req && data_req) begin
          grantInst = lastWasData;
          grantData = !lastWasData;
        end else begin
          grantInst = inst_req;
          grantData = data_req;
        end
        if (grantInst)
          stateNext = I_ADDR;
        else if (grantData)
          stateNext = (data_ben != 4'b0000) ? D_ADDR : D_SKIP;
      end
      I_ADDR:  if (bus_addr_ok) stateNext = I_DATA;
      I_DATA:  if (bus_data_ok) stateNext = IDLE;
      D_ADDR:  if (bus_addr_ok) stateNext = D_DATA;
      D_DATA:  if (bus_data_ok) stateNext = IDLE;
      D_SKIP:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lastWasData <= !DATA_FIRST;
      addrQ       <= '0;
      wdataQ      <= '0;
      wrQ         <= 1'b0;
      benQ        <= '0;
    end else begin
      state <= stateNext;
      if (grantInst) begin
        lastWasData <= 1'b0;
        addrQ       <= inst_addr;
        wdataQ      <= '0;
        wrQ         <= 1'b0;
        benQ        <= '0;
      end else if (grantData) begin
        lastWasData <= 1'b1;
        addrQ       <= data_addr;
        wdataQ      <= data_wdata;
        wrQ         <= data_wr;
        benQ        <= data_ben;
      end
    end
  end

  // Outputs come only from state and latches; rst gates them so nothing
  // leaks out in the reset cycle itself, before the state register clears.
  always_comb begin
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = 2'b00;
    bus_addr     = '0;
    bus_wstrb    = 4'b0000;
    bus_wdata    = '0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    if (!rst) begin
      case (state)
        I_ADDR: begin
          bus_req  = 1'b1;
          bus_size = SZ_WORD;
          bus_addr = addrQ;
        end
        I_DATA: begin
          inst_data_ok = bus_data_ok;
          inst_rdata   = bus_data_ok ? bus_rdata : 32'h0;
        end
        D_ADDR: begin
          bus_req   = 1'b1;
          bus_wr    = wrQ;
          bus_size  = dataSize;
          bus_addr  = addrQ;
          bus_wstrb = wrQ ? benQ : 4'b0000;
          bus_wdata = wdataQ;
        end
        D_DATA: begin
          data_data_ok = bus_data_ok;
          data_rdata   = bus_data_ok ? bus_rdata : 32'h0;
        end
        // Squashed access: acknowledge the requester without touching the bus.
        D_SKIP:  data_data_ok = 1'b1;
        default: ;
      endcase
    end
  end

  assign arb_busy = !rst && (state != IDLE);
  assign dbgState = rst ? 3'b000 : state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: table-driven data accesses plus
// hand-written multi-cycle sequences (fetch, alternation, squash, stall,
// reset mid-transaction).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_ben;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        arb_busy;
  logic [2:0]  dbgState;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mem_bus_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_ben     (data_ben),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wstrb    (bus_wstrb),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .arb_busy     (arb_busy),
    .dbgState     (dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge of the current cycle (sample point).
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    rst = 1'b0;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_ben = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  // Quiet-bus check used in reset / idle phases.
  task automatic check_quiet(input string tag);
    check({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    check({tag, "_bus_addr"}, bus_addr, 32'd0);
    check({tag, "_inst_ok"}, 32'(inst_data_ok), 32'd0);
    check({tag, "_data_ok"}, 32'(data_data_ok), 32'd0);
    check({tag, "_busy"}, 32'(arb_busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        wr;
    logic [3:0]  ben;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  expSize;
    logic [3:0]  expWstrb;
  } vec_t;

  vec_t vecs[6];

  // Full data-only access with zero wait states: grant, address phase at
  // cycle 1, data phase at cycle 2, back in IDLE at cycle 3.
  task automatic run_vec(input vec_t v);
    logic [31:0] expRdata;
    data_req = 1; data_wr = v.wr; data_ben = v.ben;
    data_addr = v.addr; data_wdata = v.wdata;
    step();
    sample();
    check({v.name, "_bus_req"}, 32'(bus_req), 32'd1);
    check({v.name, "_bus_addr"}, bus_addr, v.addr);
    check({v.name, "_bus_size"}, 32'(bus_size), 32'(v.expSize));
    check({v.name, "_bus_wstrb"}, 32'(bus_wstrb), 32'(v.expWstrb));
    check({v.name, "_bus_wr"}, 32'(bus_wr), 32'(v.wr));
    check({v.name, "_bus_wdata"}, bus_wdata, v.wdata);
    bus_addr_ok = 1;
    exp_q.push_back(v.wr ? 32'h0 : v.rdata);
    step();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = v.wr ? 32'h0 : v.rdata;
    sample();
    check({v.name, "_bus_req_dphase"}, 32'(bus_req), 32'd0);
    check({v.name, "_data_ok"}, 32'(data_data_ok), 32'd1);
    expRdata = exp_q.pop_front();
    check({v.name, "_data_rdata"}, data_rdata, expRdata);
    step();
    data_req = 0; bus_data_ok = 0; bus_rdata = 0;
    sample();
    check({v.name, "_idle_busy"}, 32'(arb_busy), 32'd0);
    check({v.name, "_idle_data_ok"}, 32'(data_data_ok), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] expAddr;
    logic        expData;

    vecs[0] = '{"byte_store", 1'b1, 4'b0100, 32'h8000_0002, 32'h5A5A_5A5A, 32'h0, 2'b00, 4'b0100};
    vecs[1] = '{"half_load",  1'b0, 4'b0011, 32'h8000_0010, 32'h1111_2222, 32'hABCD_1234, 2'b01, 4'b0000};
    vecs[2] = '{"half_store", 1'b1, 4'b1100, 32'h8000_0022, 32'hBEEF_BEEF, 32'h0, 2'b01, 4'b1100};
    vecs[3] = '{"word_store", 1'b1, 4'b1111, 32'h8000_0040, 32'h0123_4567, 32'h0, 2'b10, 4'b1111};
    vecs[4] = '{"odd_load",   1'b0, 4'b0110, 32'h8000_0051, 32'h0, 32'h7654_3210, 2'b10, 4'b0000};
    vecs[5] = '{"byte_load",  1'b0, 4'b1000, 32'h8000_0063, 32'h0, 32'h9900_0000, 2'b00, 4'b0000};

    clear_inputs();
    rst = 1'b1;
    step();
    sample();
    check_quiet("in_reset");
    check("in_reset_state", 32'(dbgState), 32'd0);
    step();
    rst = 1'b0;
    sample();
    check_quiet("after_reset");

    // Instruction fetch: addr_ok at cycle 1, data_ok at cycle 3.
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    step();
    sample();
    check("fetch_bus_req", 32'(bus_req), 32'd1);
    check("fetch_bus_addr", bus_addr, 32'hBFC0_0000);
    check("fetch_bus_size", 32'(bus_size), 32'd2);
    check("fetch_bus_wr", 32'(bus_wr), 32'd0);
    check("fetch_bus_wstrb", 32'(bus_wstrb), 32'd0);
    bus_addr_ok = 1;
    step();
    bus_addr_ok = 0;
    sample();
    check("fetch_wait_bus_req", 32'(bus_req), 32'd0);
    check("fetch_wait_inst_ok", 32'(inst_data_ok), 32'd0);
    step();
    bus_data_ok = 1; bus_rdata = 32'h2408_0001;
    sample();
    check("fetch_inst_ok", 32'(inst_data_ok), 32'd1);
    check("fetch_inst_rdata", inst_rdata, 32'h2408_0001);
    check("fetch_data_ok_quiet", 32'(data_data_ok), 32'd0);
    step();
    inst_req = 0; bus_data_ok = 0; bus_rdata = 0;
    sample();
    check("fetch_idle_busy", 32'(arb_busy), 32'd0);

    // Table-driven data accesses.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Simultaneous requests after reset: data, inst, data, inst.
    apply_reset(1);
    inst_req = 1; inst_addr = 32'h0000_1000;
    data_req = 1; data_wr = 0; data_ben = 4'b1111; data_addr = 32'h0000_2000;
    for (int g = 0; g < 4; g++) begin
      expData = (g % 2 == 0);
      expAddr = expData ? 32'h0000_2000 : 32'h0000_1000;
      step();
      sample();
      check($sformatf("alt%0d_bus_addr", g), bus_addr, expAddr);
      bus_addr_ok = 1;
      step();
      bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hC0DE_0000 + 32'(g);
      sample();
      check($sformatf("alt%0d_data_ok", g), 32'(data_data_ok), 32'(expData));
      check($sformatf("alt%0d_inst_ok", g), 32'(inst_data_ok), 32'(!expData));
      step();
      bus_data_ok = 0; bus_rdata = 0;
    end
    inst_req = 0; data_req = 0;

    // Squashed store: ack the cycle after grant, no bus activity.
    data_req = 1; data_wr = 1; data_ben = 4'b0000; data_addr = 32'hDEAD_0001;
    bus_rdata = 32'hFFFF_FFFF;
    step();
    sample();
    check("skip_data_ok", 32'(data_data_ok), 32'd1);
    check("skip_data_rdata", data_rdata, 32'd0);
    check("skip_bus_req", 32'(bus_req), 32'd0);
    data_req = 0;
    step();
    bus_rdata = 0;
    sample();
    check("skip_after_data_ok", 32'(data_data_ok), 32'd0);
    check("skip_after_bus_req", 32'(bus_req), 32'd0);
    check("skip_after_busy", 32'(arb_busy), 32'd0);

    // The squash counted as a data grant, so inst wins the next tie.
    inst_req = 1; inst_addr = 32'h0000_1004;
    data_req = 1; data_wr = 0; data_ben = 4'b1111; data_addr = 32'h0000_2004;
    step();
    sample();
    check("post_skip_tie_addr", bus_addr, 32'h0000_1004);
    bus_addr_ok = 1;
    step();
    bus_addr_ok = 0; bus_data_ok = 1;
    step();
    inst_req = 0; data_req = 0; bus_data_ok = 0;
    step();
    sample();
    check_quiet("post_tie_idle");

    // addr_ok stall with changing requester inputs and a stray data_ok.
    data_req = 1; data_wr = 1; data_ben = 4'b1111;
    data_addr = 32'h0000_3000; data_wdata = 32'hCAFE_F00D;
    step();
    for (int c = 0; c < 5; c++) begin
      data_addr = $urandom_range(32'hFFFF, 0);
      data_wdata = $urandom();
      data_ben = 4'($urandom_range(15, 0));
      data_wr = 1'($urandom_range(1, 0));
      bus_data_ok = (c == 2);
      sample();
      check($sformatf("stall%0d_bus_req", c), 32'(bus_req), 32'd1);
      check($sformatf("stall%0d_fields", c),
            {bus_addr[15:0], 8'(bus_wstrb), 4'(bus_size), 3'd0, bus_wr},
            {16'h3000, 8'h0F, 4'h2, 3'd0, 1'b1});
      check($sformatf("stall%0d_wdata", c), bus_wdata, 32'hCAFE_F00D);
      check($sformatf("stall%0d_no_ok", c), 32'(data_data_ok), 32'd0);
      step();
    end
    bus_data_ok = 0;
    data_addr = 32'h0000_3000; data_wdata = 32'hCAFE_F00D; data_ben = 4'b1111; data_wr = 1;
    bus_addr_ok = 1;
    step();
    bus_addr_ok = 0; bus_data_ok = 1;
    sample();
    check("stall_done_data_ok", 32'(data_data_ok), 32'd1);
    step();
    data_req = 0; bus_data_ok = 0;

    // Reset in D_DATA, bus_data_ok arriving one cycle later.
    data_req = 1; data_wr = 0; data_ben = 4'b1111; data_addr = 32'h0000_4000;
    step();
    bus_addr_ok = 1;
    step();
    bus_addr_ok = 0;
    sample();
    check("rst_mid_state_ddata", 32'(dbgState), 32'd4);
    rst = 1; data_req = 0;
    sample();
    check("rst_mid_gated_busy", 32'(arb_busy), 32'd0);
    step();
    rst = 0; bus_data_ok = 1; bus_rdata = 32'h1234_5678;
    sample();
    check("rst_mid_state", 32'(dbgState), 32'd0);
    check("rst_mid_data_ok", 32'(data_data_ok), 32'd0);
    check("rst_mid_data_rdata", data_rdata, 32'd0);
    check("rst_mid_bus_req", 32'(bus_req), 32'd0);
    step();
    bus_data_ok = 0; bus_rdata = 0;
    sample();
    check_quiet("rst_mid_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
